// File: rtl/adc_frame_reader.sv
// adc_frame_reader
//   Drain side of one oscilloscope channel's ADC capture FIFO. A host start
//   arms the capture block, waits for the capture to complete, then pops up
//   to FRAME_LEN samples and forwards them over a valid/ready byte link as
//   one frame: A5, CH_ID, samples[, checksum].
//
//   Build option: define ADC_FRAME_CSUM_EN to append an 8-bit additive
//   checksum of the sample bytes as the last byte of every frame. Without it
//   the frame ends after the last sample and the checksum logic is absent.
//
// Parameters
//   FRAME_LEN  samples read per frame, 1..8191
//   CH_ID      channel identifier carried in the second header byte
//
// Ports
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   start      one-cycle frame request, honoured only when idle
//   cap_bg     one-cycle arm pulse to the capture block
//   cap_end    capture complete, FIFO readable
//   cap_empty  capture FIFO empty
//   cap_rdreq  FIFO pop; data appears on cap_data the following cycle
//   cap_data   FIFO read data (normal mode)
//   tx_data    byte to link
//   tx_valid   tx_data valid
//   tx_ready   link accepts when tx_valid & tx_ready
//   busy       high whenever a frame is in progress
//   done       one-cycle pulse when the frame has finished
//   short_err  sticky: FIFO ran dry before FRAME_LEN samples; cleared by start

module adc_frame_reader #(
  parameter int          FRAME_LEN = 4096,
  parameter logic [7:0]  CH_ID     = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  output logic       cap_bg,
  input  logic       cap_end,
  input  logic       cap_empty,
  output logic       cap_rdreq,
  input  logic [7:0] cap_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       short_err
);

  localparam logic [12:0] LEN  = 13'(FRAME_LEN);
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT, S_HDR0, S_HDR1, S_POP, S_LAT, S_SEND, S_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q;       // samples forwarded so far in this frame
  logic [7:0]  sample_q;    // sample being presented in SEND
  logic        short_q;
  logic        done_q;
`ifdef ADC_FRAME_CSUM_EN
  logic [7:0]  csum_q;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)    state_d = S_ARM;
      S_ARM:                state_d = S_WAIT;
      S_WAIT: if (cap_end)  state_d = S_HDR0;
      S_HDR0: if (tx_ready) state_d = S_HDR1;
      S_HDR1: if (tx_ready) state_d = S_POP;
      // An empty FIFO here ends the frame early rather than stalling.
      S_POP:                state_d = cap_empty ? S_TAIL : S_LAT;
      S_LAT:                state_d = S_SEND;
      S_SEND: if (tx_ready) state_d = (cnt_q == LEN) ? S_TAIL : S_POP;
`ifdef ADC_FRAME_CSUM_EN
      S_TAIL: if (tx_ready) state_d = S_IDLE;
`else
      S_TAIL:               state_d = S_IDLE;
`endif
      default:              state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: counter, sample register, checksum, status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q    <= '0;
      sample_q <= '0;
      short_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          cnt_q   <= '0;
          short_q <= 1'b0;
        end
        S_POP:  if (cap_empty) short_q <= 1'b1;
        // Counter stops at FRAME_LEN, so 13 bits never wrap.
        S_LAT: begin
          sample_q <= cap_data;
          cnt_q    <= cnt_q + 13'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADC_FRAME_CSUM_EN
  // Sum mod 256 of sample bytes only; header bytes never enter it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                       csum_q <= '0;
    else if (state_q == S_IDLE && start) csum_q <= '0;
    else if (state_q == S_LAT)          csum_q <= csum_q + cap_data;
  end
`endif

  // done lands in the cycle after the final byte is accepted. With the
  // checksum that byte leaves in TAIL; without it the last sample leaves
  // in SEND and TAIL itself is that following cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) done_q <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
    else          done_q <= (state_q == S_TAIL) && tx_ready;
`else
    else          done_q <= (state_d == S_TAIL);
`endif
  end

  // ---------------------------------------------------------------------
  // Output logic (decoded from registered state, so reset is immediate)
  // ---------------------------------------------------------------------
  always_comb begin
    cap_bg    = 1'b0;
    cap_rdreq = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state_q)
      S_ARM:  cap_bg    = 1'b1;
      S_POP:  cap_rdreq = !cap_empty;
      S_HDR0: begin tx_valid = 1'b1; tx_data = SYNC;     end
      S_HDR1: begin tx_valid = 1'b1; tx_data = CH_ID;    end
      S_SEND: begin tx_valid = 1'b1; tx_data = sample_q; end
`ifdef ADC_FRAME_CSUM_EN
      S_TAIL: begin tx_valid = 1'b1; tx_data = csum_q;   end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign short_err = short_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: FIFO model, link with selectable ready
// patterns, and a frame-level expectation queue built from the FIFO
// contents (A5, CH_ID, first min(n,FRAME_LEN) samples, optional sum).

module tb_adc_frame_reader;
  localparam int         FL   = 8;
  localparam logic [7:0] CHID = 8'h00;
`ifdef ADC_FRAME_CSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic       Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
  logic       cap_end = 1'b0, cap_empty = 1'b1, tx_ready = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_bg, cap_rdreq, tx_valid, busy, done, short_err;
  logic [7:0] tx_data;

  always #5 Clk = ~Clk;

  adc_frame_reader #(.FRAME_LEN(FL), .CH_ID(CHID)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .cap_bg(cap_bg),
    .cap_end(cap_end), .cap_empty(cap_empty), .cap_rdreq(cap_rdreq),
    .cap_data(cap_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .short_err(short_err)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0] fifo_q[$], exp_q[$], got_q[$], lit[$];
  int cyc = 0, bg_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int first_v_cyc = -1, end_cyc = -1, done_cyc = -1, last_acc_cyc = -1;
  bit busy_at_done = 1'b0, rd_seen = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int rdy_mode = 1, arm_cnt = 0;

  task automatic chk_eq(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge Clk) begin
    cyc++;
    rd_seen = Reset_n && cap_rdreq;
    if (Reset_n) begin
      if (cap_bg) bg_cnt++;
      if (cap_rdreq) chk_eq("rdreq_while_empty", cap_empty, 0);
      if (prev_hold) begin
        chk_eq("hold_valid", tx_valid, 1);
        chk_eq("hold_data", tx_data, prev_data);
      end
      if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (cap_end && bg_cnt > 0 && !cap_bg && first_v_cyc < 0 && end_cyc < 0) end_cyc = cyc;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        acc_cnt++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) chk_eq("extra_byte", 1, 0);
        else                   chk_eq("stream_byte", tx_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Environment: FIFO (normal read mode), capture-end generator, link ready.
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (rd_seen && fifo_q.size() > 0) cap_data = fifo_q.pop_front();
      cap_empty = (fifo_q.size() == 0);
      if (cap_bg) begin
        cap_end = 1'b0;
        arm_cnt = 2 + $urandom_range(0, 4);
      end else if (arm_cnt > 0) begin
        arm_cnt--;
        if (arm_cnt == 0) cap_end = 1'b1;
      end
      case (rdy_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        2:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_cap_bg"},    cap_bg,    0);
    chk_eq({tag, "_cap_rdreq"}, cap_rdreq, 0);
    chk_eq({tag, "_tx_data"},   tx_data,   0);
    chk_eq({tag, "_tx_valid"},  tx_valid,  0);
    chk_eq({tag, "_busy"},      busy,      0);
    chk_eq({tag, "_done"},      done,      0);
    chk_eq({tag, "_short_err"}, short_err, 0);
  endtask

  // Expected frame from the FIFO contents as loaded.
  task automatic build_exp(output bit exp_short);
    int n, cs;
    n = (fifo_q.size() < FL) ? fifo_q.size() : FL;
    exp_short = (n < FL);
    exp_q.delete(); got_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(CHID);
    cs = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(fifo_q[i]);
      cs += fifo_q[i];
    end
    if (CSUM != 0) exp_q.push_back(8'(cs));
    bg_cnt = 0; done_cnt = 0; acc_cnt = 0;
    first_v_cyc = -1; end_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
  endtask

  task automatic pulse_start();
    @(posedge Clk); #2; start = 1'b1;
    @(posedge Clk); #2; start = 1'b0;
    chk_eq("cap_bg_after_start", cap_bg, 1);
    chk_eq("short_err_cleared", short_err, 0);
    chk_eq("busy_in_arm", busy, 1);
  endtask

  task automatic run_frame(input int mode, input bit extra, input bit tchk);
    bit exp_short;
    build_exp(exp_short);
    rdy_mode = mode;
    pulse_start();
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      @(posedge Clk); #2;
      if (start) start = 1'b0;
      else if (extra && busy && $urandom_range(0, 2) == 0) start = 1'b1;
    end
    start = 1'b0;
    chk_eq("frame_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) @(posedge Clk);
    #2;
    chk_eq("done_count", done_cnt, 1);
    chk_eq("cap_bg_count", bg_cnt, 1);
    chk_eq("bytes_left", exp_q.size(), 0);
    chk_eq("short_err", short_err, exp_short);
    chk_eq("busy_idle", busy, 0);
    if (CSUM != 0) chk_eq("busy_at_done", busy_at_done, 0);
    if (!exp_short || CSUM != 0) chk_eq("done_after_last_accept", done_cyc - last_acc_cyc, 1);
    if (tchk) begin
      chk_eq("hdr_latency", first_v_cyc - end_cyc, 1);
      chk_eq("frame_cycles", done_cyc - first_v_cyc, 2 + 3 * FL + CSUM);
    end
    fifo_q.delete();
  endtask

  task automatic chk_literal(input string name);
    chk_eq({name, "_len"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++)
      chk_eq({name, "_byte"}, got_q[i], lit[i]);
  endtask

  initial begin
    bit es;
    #12;
    chk_reset_outs("reset");
    @(posedge Clk); #3; Reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    // Full frame 1..8, link always ready.
    for (int i = 1; i <= FL; i++) fifo_q.push_back(8'(i));
    run_frame(1, 1'b0, 1'b1);
    lit = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    if (CSUM == 0) void'(lit.pop_back());
    chk_literal("lit_full");

    // Same frame, ready 1-of-3, stray starts while busy.
    for (int i = 1; i <= FL; i++) fifo_q.push_back(8'(i));
    run_frame(2, 1'b1, 1'b0);
    chk_literal("lit_throttled");

    // Short frame: five FF samples.
    repeat (5) fifo_q.push_back(8'hFF);
    run_frame(3, 1'b1, 1'b0);
    lit = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB};
    if (CSUM == 0) void'(lit.pop_back());
    chk_literal("lit_short");
    repeat (5) @(posedge Clk);
    #2;
    chk_eq("short_err_sticky", short_err, 1);

    // Random contents and lengths, random ready.
    repeat (8) begin
      int n;
      n = $urandom_range(0, FL + 3);
      for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
      run_frame(3, 1'b1, 1'b0);
    end

    // Reset during the third sample's SEND.
    for (int i = 0; i < FL; i++) fifo_q.push_back(8'($urandom));
    build_exp(es);
    rdy_mode = 1;
    pulse_start();
    begin
      int k;
      for (k = 0; k < 200 && acc_cnt < 4; k++) @(posedge Clk);
      if (k == 200) chk_eq("timeout_mid_accepts", acc_cnt, 4);
      #2; rdy_mode = 0; tx_ready = 1'b0;
      for (k = 0; k < 20 && !tx_valid; k++) begin @(posedge Clk); #2; end
      if (k == 20) chk_eq("timeout_mid_send", tx_valid, 1);
    end
    chk_eq("mid_send_valid", tx_valid, 1);
    #1; Reset_n = 1'b0;
    #1; chk_reset_outs("async_reset");
    @(posedge Clk); @(posedge Clk); #2;
    exp_q.delete(); fifo_q.delete();
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    for (int i = 0; i < FL; i++) fifo_q.push_back(8'($urandom));
    run_frame(1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
